mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width (legal values 8 to 64).
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 0, the signed ops execute as their unsigned equivalents.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset, with ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- Start  in  1  request; sampled on clk.
- Op  in  2  operation: 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV.
- SrcA  in  WIDTH  multiplicand or dividend.
- SrcB  in  WIDTH  multiplier or divisor.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- ResultLo  out  WIDTH  low product half, or quotient.
- ResultHi  out  WIDTH  high product half, or remainder.
- DivByZero  out  1  last completed divide had SrcB == 0.

Function
REQ-004 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-005 Start SHALL be accepted only in IDLE or DONE.
- On acceptance, Op, SrcA and SrcB SHALL be latched and the FSM SHALL go to RUN.
- Start in RUN SHALL be ignored.
REQ-006 RUN SHALL last exactly WIDTH cycles, one radix-2 iteration per cycle, after which the FSM SHALL go to DONE.
REQ-007 DONE SHALL last one cycle; without an accepted Start it SHALL return to IDLE.
- Start in DONE SHALL be accepted, giving back-to-back operation with no bubble.
REQ-008 Busy SHALL be 1 exactly in RUN; Done SHALL be 1 exactly in DONE.
- Done SHALL occur WIDTH+1 cycles after the accepting edge, with uniform latency for all ops including divide-by-zero.
REQ-009 ResultLo, ResultHi and DivByZero SHALL update only on entry to DONE.
- They SHALL hold stable until the next DONE.
- Input changes during RUN SHALL have no effect.
REQ-010 Multiply: {ResultHi,ResultLo} SHALL be the exact 2*WIDTH-bit product; SMUL SHALL use two's-complement operands.
REQ-011 Divide: ResultLo SHALL be the quotient and ResultHi the remainder.
- SDIV SHALL truncate toward zero.
- The remainder SHALL take the sign of the dividend.
REQ-012 Signed ops SHALL use the sign-magnitude method: magnitudes, an unsigned core, then conditional negation at DONE entry.
REQ-013 Divide with SrcB == 0 SHALL give quotient all-ones, remainder SrcA and DivByZero 1; otherwise DivByZero SHALL be 0 at DONE.
- Multiply SHALL clear DivByZero at DONE.
REQ-014 SDIV of the most negative value by -1 SHALL give quotient equal to the most negative value, remainder 0, DivByZero 0.
REQ-015 Internal arithmetic SHALL be WIDTH+1 bits for the partial remainder and 2*WIDTH bits for the product accumulator, with no overflow loss.

Reset
REQ-016 Asserting reset (low) SHALL immediately force:
- state IDLE;
- Busy 0, Done 0, DivByZero 0;
- ResultLo and ResultHi to 0;
- the iteration counter and internal registers to 0.
REQ-017 Reset during RUN SHALL abandon the operation with no Done pulse.
REQ-018 After reset release, the first rising edge with Start=1 SHALL be accepted.

Structure
REQ-019 A shared package SHALL hold:
- the Op encodings (OP_UMUL, OP_SMUL, OP_UDIV, OP_SDIV);
- the FSM state encoding.
REQ-020 The per-cycle shift-add / restoring-subtract datapath SHALL be a sub-module mdu_step.
- The FSM, counter, latches and sign fix-up SHALL stay in mul_div_unit.
REQ-021 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-022 The bench SHALL use WIDTH=32, SIGNED_EN=1 and cover these directed scenarios:
- UMUL 0xFFFFFFFF*0xFFFFFFFF: Hi 0xFFFFFFFE, Lo 0x00000001; Done exactly 33 cycles after Start; Busy high cycles 1-32.
- SMUL -3*7: Hi 0xFFFFFFFF, Lo 0xFFFFFFEB.
- UDIV 100/7: Q 14, R 2.
- SDIV -7/2: Q 0xFFFFFFFD, R 0xFFFFFFFF.
- UDIV 5/0: Q 0xFFFFFFFF, R 5, DivByZero 1.
- SDIV 0x80000000/0xFFFFFFFF: Q 0x80000000, R 0.
- Back-to-back: Start held through DONE; the second op is accepted in the DONE cycle and its Done follows 33 cycles later.
- Start pulsed with new operands at RUN cycle 5: ignored, results unchanged.
- reset low at RUN cycle 10: Busy 0 immediately, results 0, no Done pulse.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and small decode helpers.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_UMUL = 2'b00,
        OP_SMUL = 2'b01,
        OP_UDIV = 2'b10,
        OP_SDIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Divide operations select the restoring-subtract path.
    function automatic logic op_is_div(input op_e op);
        return (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

    // Operations that interpret their operands as two's complement.
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_SMUL) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration of the unsigned core: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,      // mul: {partial product, multiplier}; div: low half = dividend/quotient
    input  logic [WIDTH-1:0]   rem,      // div: partial remainder, always < divisor between steps
    input  logic [WIDTH-1:0]   opb,      // mul: multiplicand magnitude; div: divisor magnitude
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0]   rem_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Compute both iteration flavours and select by operation class.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        acc_nxt = {sum, acc[WIDTH-1:1]};
        rem_nxt = rem;
        if (is_div) begin
            // A clear top bit of diff means the trial subtraction did not borrow.
            if (!diff[WIDTH]) begin
                rem_nxt = diff[WIDTH-1:0];
                acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end else begin
                rem_nxt = shifted[WIDTH-1:0];
                acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit. Signed operations run on operand
// magnitudes through an unsigned core and are sign-corrected on DONE entry.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e state_q, state_d;
    logic   accept;
    logic   last_iter;

    logic [2*WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0]   rem_q, rem_nxt;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               neg_q;       // quotient / product needs negation
    logic               neg_rem_q;   // remainder takes the dividend's sign
    logic               dbz_q;

    // Operand decode for the accepting edge.
    op_e              op_in;
    logic             in_div;
    logic             in_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Sign fix-up of the final iteration, registered on DONE entry.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_in     = op_e'(Op);
    assign in_div    = op_is_div(op_in);
    assign in_signed = SIGNED_EN && op_is_signed(op_in);
    assign a_neg     = in_signed && SrcA[WIDTH-1];
    assign b_neg     = in_signed && SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;

    assign Busy = (state_q == ST_RUN);
    assign Done = (state_q == ST_DONE);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc     (acc_q),
        .rem     (rem_q),
        .opb     (opb_q),
        .acc_nxt (acc_nxt),
        .rem_nxt (rem_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; Start is honoured only in IDLE and DONE.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                last_iter = (cnt_q == CW'(WIDTH - 1));
                if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch on acceptance, then one core iteration per RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (accept) begin
            acc_q     <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
            rem_q     <= '0;
            opb_q     <= in_div ? b_mag : a_mag;
            a_raw_q   <= SrcA;
            cnt_q     <= '0;
            is_div_q  <= in_div;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= in_div && (SrcB == '0);
        end else if (state_q == ST_RUN) begin
            acc_q <= acc_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Apply the sign-magnitude correction to the last iteration's output.
    always_comb begin
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -rem_nxt : rem_nxt;
    end

    // Result registers load only on the RUN -> DONE transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ResultLo  <= '0;
            ResultHi  <= '0;
            DivByZero <= 1'b0;
        end else if (last_iter) begin
            if (!is_div_q) begin
                ResultLo  <= prod_fix[WIDTH-1:0];
                ResultHi  <= prod_fix[2*WIDTH-1:WIDTH];
                DivByZero <= 1'b0;
            end else if (dbz_q) begin
                // Divide by zero reports the raw dividend, bypassing sign fix-up.
                ResultLo  <= '1;
                ResultHi  <= a_raw_q;
                DivByZero <= 1'b1;
            end else begin
                ResultLo  <= quo_fix;
                ResultHi  <= rem_fix;
                DivByZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32, SIGNED_EN=1).
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] SrcA, SrcB;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] ResultLo, ResultHi;

    typedef struct {
        string        tag;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Busy      (Busy),
        .Done      (Done),
        .ResultLo  (ResultLo),
        .ResultHi  (ResultHi),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation with Start high and record its expected result.
    task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic dbz);
        exp_t e;
        Op = op; SrcA = a; SrcB = b; Start = 1'b1;
        e.tag = tag; e.lo = lo; e.hi = hi; e.dbz = dbz;
        sb.push_back(e);
    endtask

    // Called just after the accepting edge (or later); waits for Done with a bound.
    task automatic wait_done(input int exp_lat);
        int   n;
        bit   busy_ok;
        exp_t e;
        n = 0;
        busy_ok = 1'b1;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_has_entry", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, 64'(Done), 64'd1);
        check({e.tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({e.tag, "_busy_in_run"}, 64'(busy_ok), 64'd1);
        check({e.tag, "_busy_in_done"}, 64'(Busy), 64'd0);
        check({e.tag, "_lo"}, 64'(ResultLo), 64'(e.lo));
        check({e.tag, "_hi"}, 64'(ResultHi), 64'(e.hi));
        check({e.tag, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
    endtask

    // Complete one isolated operation and return to IDLE.
    task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] lo,
                       input logic [W-1:0] hi, input logic dbz);
        issue(tag, op, a, b, lo, hi, dbz);
        tick();
        Start = 1'b0;
        wait_done(W);
        tick();
    endtask

    int done_cnt;
    int busy_cnt;

    initial begin
        reset = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
        repeat (3) tick();
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_lo", 64'(ResultLo), 64'd0);
        check("rst_hi", 64'(ResultHi), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        #4 reset = 1'b1;

        // First edge after release must accept; latency checked inside.
        run("umul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run("smul_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        run("udiv_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("udiv_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);

        // Back-to-back: Start held; second operands presented during RUN are ignored there.
        issue("b2b_first", 2'b10, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        tick();
        issue("b2b_second", 2'b01, 32'd6, 32'hFFFF_FFFB, 32'hFFFF_FFE2, 32'hFFFF_FFFF, 1'b0);
        wait_done(W);
        tick();
        Start = 1'b0;
        check("b2b_no_bubble_busy", 64'(Busy), 64'd1);
        check("b2b_no_bubble_done", 64'(Done), 64'd0);
        wait_done(W);
        tick();

        // Start pulse with new operands at RUN cycle 5 is ignored.
        issue("umul_3x4", 2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Op = 2'b10; SrcA = 32'd9; SrcB = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(W - 5);
        tick();
        check("ignored_back_idle_busy", 64'(Busy), 64'd0);
        check("ignored_back_idle_done", 64'(Done), 64'd0);
        check("ignored_result_held", 64'(ResultLo), 64'd12);

        // Reset at RUN cycle 10 abandons the operation.
        Op = 2'b01; SrcA = 32'hFFFF_FFFD; SrcB = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check("pre_reset_busy", 64'(Busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset_busy", 64'(Busy), 64'd0);
        check("mid_reset_done", 64'(Done), 64'd0);
        check("mid_reset_lo", 64'(ResultLo), 64'd0);
        check("mid_reset_hi", 64'(ResultHi), 64'd0);
        check("mid_reset_dbz", 64'(DivByZero), 64'd0);
        repeat (2) tick();
        #4 reset = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done === 1'b1) done_cnt++;
            if (Busy === 1'b1) busy_cnt++;
        end
        check("abandoned_no_done", 64'(done_cnt), 64'd0);
        check("abandoned_no_busy", 64'(busy_cnt), 64'd0);

        run("post_reset_umul", 2'b00, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
